lcd_timing_gen: RTL and testbench
=================================

// Module: lcd_timing_gen
// PURPOSE
// Parametrised LCD timing generator and STAT/LY register block. Successor to the fixed DMG video control.
// - Runs a dot counter and a line counter, and derives the PPU mode (OAM/DRAW/HBLANK/VBLANK).
// - Compares LY against LYC and raises the VBLANK and STAT interrupts.
// - Sits between the CPU bus decoder (register access) and the PPU fetch/pixel pipeline (mode, draw_done).
// PARAMETERS
// H_TOTAL   456  dots per line
// H_OAM     80   dots of OAM search at start of each visible line
// V_ACTIVE  144  visible lines
// V_TOTAL   154  total lines per frame
// H_BITS    9    dot counter width; must satisfy 2**H_BITS >= H_TOTAL
// PORTS
// clk2         in   1   dot clock, all state on rising edge
// reset_video  in   1   synchronous active-high reset
// lcd_en       in   1   LCDC bit 7; 0 = display off
// draw_done    in   1   PPU finished pixel transfer for current line (level, sampled in DRAW)
// cpu_wr       in   1   register write strobe, one clk2 cycle
// cpu_rd       in   1   register read strobe, one clk2 cycle
// reg_sel      in   2   0 = STAT, 1 = LY (read-only), 2 = LYC, 3 = reserved
// wdata        in   8   write data
// rdata        out  8   read data, registered
// dot          out  H_BITS  current dot in line
// ly           out  8   current line (LY as read by CPU)
// mode         out  2   0 HBLANK, 1 VBLANK, 2 OAM, 3 DRAW
// line_start   out  1   pulse: dot==0 of any line
// int_vbl      out  1   one-cycle pulse entering line V_ACTIVE
// int_stat     out  1   one-cycle pulse on rising edge of internal STAT line
// BEHAVIOUR
// - Reset: dot = 0, ly = 0, mode = 0, LYC = 0, STAT enables = 0, rdata = 0, all pulses 0, stat_line = 0.
// - Display off (lcd_en=0): dot, ly and mode held at 0; stat_line forced 0; no pulses. Registers stay writable.
// - Counting (lcd_en=1): dot += 1 per clk2.
//   - At dot==H_TOTAL-1, dot wraps to 0 and ly += 1.
//   - ly wraps V_TOTAL-1 -> 0.
// - Mode FSM, registered, evaluated per dot:
//   - ly < V_ACTIVE:
//     - OAM for dots 0..H_OAM-1.
//     - DRAW from dot H_OAM until draw_done is sampled high; mode is 0 on the following cycle.
//     - HBLANK until line end.
//   - ly >= V_ACTIVE: VBLANK for the whole line.
//   - DRAW without draw_done by dot H_TOTAL-1: line ends anyway and the next line enters OAM (no hang).
//   - draw_done outside DRAW: ignored.
// - Enable quirk: the first line after lcd_en rises 0->1 starts in HBLANK instead of OAM. It then enters DRAW at H_OAM as normal.
// - int_vbl: one pulse on the cycle mode becomes VBLANK (ly==V_ACTIVE, dot==0).
// - Coincidence flag: STAT bit 2 = (ly == LYC), updated every cycle; frozen while lcd_en=0.
// - stat_line = OR of the enabled sources:
//   - bit6 & coincidence
//   - bit5 & OAM
//   - bit4 & VBLANK
//   - bit3 & HBLANK
// - int_stat: pulses only on a 0->1 transition of stat_line. Back-to-back sources with no low gap give exactly one pulse (STAT blocking).
// - Writes take effect on the next cycle.
//   - STAT: bits 6:3 are writable; bits 2:0 and bit 7 are ignored.
//   - LYC: all 8 bits.
//   - LY and reserved: no effect.
// - Reads: rdata is valid the cycle after cpu_rd and holds until the next read.
//   - STAT reads {1'b1, en[3:0], coinc, mode}.
//   - Reserved reads 8'hFF.
// - Simultaneous cpu_wr to LYC and a matching ly: coincidence uses the old LYC on that cycle and the new LYC after.
// - reset_video mid-frame: everything returns to reset values next cycle, including LYC and the enables.
// CONFIGURATION
// - LCD_LINE153_QUIRK_EN defined:
//   - On line V_TOTAL-1, the ly output and the coincidence compare read 0 from dot 4 onward.
//   - The internal line counter still wraps normally.
//   - LYC==0 may therefore fire twice per frame: line V_TOTAL-1 and line 0.
// - LCD_LINE153_QUIRK_EN undefined: ly always equals the internal line counter.
// TESTING
// 1. Reset asserted 3 cycles with lcd_en=1 -> dot=0, ly=0, mode=0, rdata=0, no pulses.
// 2. Defaults, enable, draw_done at dot 252 of line 1 -> mode 2 dots 0-79, mode 3 dots 80-252, mode 0 dots 253-455.
// 3. Line 0 after enable -> mode 0 dots 0-79, then mode 3 at dot 80.
// 4. Run to ly=144 -> int_vbl single pulse at dot 0, mode=1 for lines 144-153, ly 153 -> 0 -> mode 2.
// 5. LYC=5, STAT en=bit6 -> int_stat exactly one pulse at ly=5 dot 0; STAT read = 8'hC6 during OAM of line 5.
// 6. STAT en = bit3|bit5, no draw_done -> forced HBLANK-free line, one int_stat per line at OAM start.
// 7. With LCD_LINE153_QUIRK_EN, LYC=0, en bit6 -> int_stat at ly 153 dot 4, ly reads 0 there; no new pulse at line 0 (blocked).

Source files
------------

// File: rtl/lcd_timing_gen_if.sv
// CPU register bus between the bus decoder and the LCD timing/STAT block.
// Strobes are single-cycle; rdata is registered inside the slave.
// No backpressure: every strobe is accepted on the cycle it is seen.
interface lcd_timing_gen_if;
    logic       cpu_wr;
    logic       cpu_rd;
    logic [1:0] reg_sel;
    logic [7:0] wdata;
    logic [7:0] rdata;

    modport master (output cpu_wr, cpu_rd, reg_sel, wdata, input rdata);
    modport slave  (input cpu_wr, cpu_rd, reg_sel, wdata, output rdata);
endinterface

// File: rtl/lcd_timing_gen.sv
// LCD dot/line timing, PPU mode FSM, LY/LYC/STAT registers and VBLANK/STAT interrupts.
// Latency: all outputs registered; register writes visible next cycle, reads one cycle after cpu_rd.
// Backpressure: none; runs one dot per clk2. Optional LCD_LINE153_QUIRK_EN makes LY read 0 on the last line from dot 4.
module lcd_timing_gen #(
    parameter int H_TOTAL  = 456,
    parameter int H_OAM    = 80,
    parameter int V_ACTIVE = 144,
    parameter int V_TOTAL  = 154,
    parameter int H_BITS   = 9      // 2**H_BITS must cover H_TOTAL
) (
    input  logic              clk2,
    input  logic              reset_video,
    input  logic              lcd_en,
    input  logic              draw_done,
    lcd_timing_gen_if.slave   bus,
    output logic [H_BITS-1:0] dot,
    output logic [7:0]        ly,
    output logic [1:0]        mode,
    output logic              line_start,
    output logic              int_vbl,
    output logic              int_stat
);

    typedef enum logic [1:0] {
        MODE_HBLANK = 2'd0,
        MODE_VBLANK = 2'd1,
        MODE_OAM    = 2'd2,
        MODE_DRAW   = 2'd3
    } mode_e;

    localparam logic [H_BITS-1:0] DOT_LAST  = H_BITS'(H_TOTAL - 1);
    localparam logic [H_BITS-1:0] DOT_DRAW  = H_BITS'(H_OAM);
    localparam logic [7:0]        LINE_LAST = 8'(V_TOTAL - 1);
    localparam logic [7:0]        LINE_VBL  = 8'(V_ACTIVE);

    logic [H_BITS-1:0] dot_q, dot_d;
    logic [7:0]        line_q, line_d;     // internal line counter, always wraps normally
    logic [7:0]        ly_q, ly_d;         // LY as presented to the CPU
    mode_e             mode_q, mode_d;
    logic [7:0]        lyc_q, lyc_d;
    logic [3:0]        en_q, en_d;         // STAT enables, bits 6:3
    logic              coinc_q, coinc_d;
    logic              stat_q, stat_d;
    logic              int_vbl_q, int_vbl_d;
    logic              int_stat_q, int_stat_d;
    logic              line_start_q, line_start_d;
    logic [7:0]        rdata_q, rdata_d;

    // Dot and line counters; both collapse to 0 while the display is off.
    always_comb begin
        dot_d  = '0;
        line_d = '0;
        if (lcd_en) begin
            if (dot_q == DOT_LAST) begin
                dot_d  = '0;
                line_d = (line_q == LINE_LAST) ? 8'd0 : line_q + 8'd1;
            end else begin
                dot_d  = dot_q + H_BITS'(1);
                line_d = line_q;
            end
        end
`ifdef LCD_LINE153_QUIRK_EN
        ly_d = (line_d == LINE_LAST && dot_d >= H_BITS'(4)) ? 8'd0 : line_d;
`else
        ly_d = line_d;
`endif
    end

    // Mode FSM next state, aligned with the next dot/line so mode matches the dot it is shown with.
    // Line 0 after enable starts in HBLANK because the held-off state is mode 0 at dot 0 and
    // OAM is only entered on a dot wrap.
    always_comb begin
        mode_d = mode_q;
        if (!lcd_en) begin
            mode_d = MODE_HBLANK;
        end else if (line_d >= LINE_VBL) begin
            mode_d = MODE_VBLANK;
        end else if (dot_d == '0) begin
            mode_d = MODE_OAM;
        end else if (dot_d == DOT_DRAW) begin
            mode_d = MODE_DRAW;
        end else if (mode_q == MODE_DRAW && draw_done) begin
            mode_d = MODE_HBLANK;
        end
    end

    // Coincidence, STAT line and interrupt pulses; coincidence uses the LYC already in the register.
    always_comb begin
        coinc_d = coinc_q;
        stat_d  = 1'b0;
        if (lcd_en) begin
            coinc_d = (ly_d == lyc_q);
            stat_d  = (en_q[3] & coinc_d)
                    | (en_q[2] & (mode_d == MODE_OAM))
                    | (en_q[1] & (mode_d == MODE_VBLANK))
                    | (en_q[0] & (mode_d == MODE_HBLANK));
        end
        int_stat_d   = stat_d & ~stat_q;
        int_vbl_d    = lcd_en && (mode_d == MODE_VBLANK) && (mode_q != MODE_VBLANK);
        line_start_d = lcd_en && (dot_d == '0);
    end

    // CPU register writes and registered reads.
    always_comb begin
        lyc_d   = lyc_q;
        en_d    = en_q;
        rdata_d = rdata_q;
        if (bus.cpu_wr) begin
            case (bus.reg_sel)
                2'd0:    en_d  = bus.wdata[6:3];
                2'd2:    lyc_d = bus.wdata;
                default: ;
            endcase
        end
        if (bus.cpu_rd) begin
            case (bus.reg_sel)
                2'd0:    rdata_d = {1'b1, en_q, coinc_q, mode_q};
                2'd1:    rdata_d = ly_q;
                2'd2:    rdata_d = lyc_q;
                default: rdata_d = 8'hFF;
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk2) begin
        if (reset_video) begin
            dot_q        <= '0;
            line_q       <= '0;
            ly_q         <= '0;
            mode_q       <= MODE_HBLANK;
            lyc_q        <= '0;
            en_q         <= '0;
            coinc_q      <= 1'b0;
            stat_q       <= 1'b0;
            int_vbl_q    <= 1'b0;
            int_stat_q   <= 1'b0;
            line_start_q <= 1'b0;
            rdata_q      <= '0;
        end else begin
            dot_q        <= dot_d;
            line_q       <= line_d;
            ly_q         <= ly_d;
            mode_q       <= mode_d;
            lyc_q        <= lyc_d;
            en_q         <= en_d;
            coinc_q      <= coinc_d;
            stat_q       <= stat_d;
            int_vbl_q    <= int_vbl_d;
            int_stat_q   <= int_stat_d;
            line_start_q <= line_start_d;
            rdata_q      <= rdata_d;
        end
    end

    assign dot        = dot_q;
    assign ly         = ly_q;
    assign mode       = mode_q;
    assign line_start = line_start_q;
    assign int_vbl    = int_vbl_q;
    assign int_stat   = int_stat_q;
    assign bus.rdata  = rdata_q;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Scoreboard bench for lcd_timing_gen: expected reads, pulses and timing checkpoints are queued
// by the stimulus process and consumed by an independent monitor on the falling clock edge.
module tb_lcd_timing_gen;

    localparam int H = 456;
`ifdef LCD_LINE153_QUIRK_EN
    localparam int LY153 = 0;
    localparam int LAST_STAT_DOT = 4;
`else
    localparam int LY153 = 153;
    localparam int LAST_STAT_DOT = 0;
`endif

    typedef struct { int k; int dot; int ly; int mode; int ls; } cp_t;
    typedef struct { int ly; int dot; } ev_t;

    logic       clk2 = 1'b0;
    logic       reset_video;
    logic       lcd_en;
    logic       draw_done;
    logic [8:0] dot;
    logic [7:0] ly;
    logic [1:0] mode;
    logic       line_start;
    logic       int_vbl;
    logic       int_stat;

    lcd_timing_gen_if bus();

    lcd_timing_gen dut (
        .clk2        (clk2),
        .reset_video (reset_video),
        .lcd_en      (lcd_en),
        .draw_done   (draw_done),
        .bus         (bus.slave),
        .dot         (dot),
        .ly          (ly),
        .mode        (mode),
        .line_start  (line_start),
        .int_vbl     (int_vbl),
        .int_stat    (int_stat)
    );

    always #5 clk2 = ~clk2;

    int checks = 0;
    int errors = 0;
    int en_cnt = 0;
    bit rd_pend = 1'b0;

    cp_t        cp_q[$];
    ev_t        stat_ev_q[$];
    ev_t        vbl_ev_q[$];
    logic [7:0] rd_q[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d (t=%0t en_cnt=%0d)", name, act, exp, $time, en_cnt);
        end
    endtask

    task automatic add_cp(input int k, input int d, input int l, input int m, input int ls);
        cp_t c;
        c.k = k; c.dot = d; c.ly = l; c.mode = m; c.ls = ls;
        cp_q.push_back(c);
    endtask

    task automatic add_ev_stat(input int l, input int d);
        ev_t e;
        e.ly = l; e.dot = d;
        stat_ev_q.push_back(e);
    endtask

    // Enabled-cycle counter: after k enabled edges the DUT should sit at line k/H, dot k%H.
    always @(posedge clk2) begin
        if (lcd_en && !reset_video) en_cnt++;
        rd_pend = bus.cpu_rd;
    end

    // Monitor: consumes expectations whenever the DUT presents read data, pulses or a checkpoint.
    always @(negedge clk2) begin
        if (rd_pend) begin
            if (rd_q.size() == 0) chk("rdata_unexpected_read", 1, 0);
            else chk("rdata", int'(bus.rdata), int'(rd_q.pop_front()));
        end
        if (int_stat) begin
            if (stat_ev_q.size() == 0) chk("int_stat_unexpected", int'(ly) * 1000 + int'(dot), -1);
            else begin
                ev_t e;
                e = stat_ev_q.pop_front();
                chk("int_stat_ly", int'(ly), e.ly);
                chk("int_stat_dot", int'(dot), e.dot);
            end
        end
        if (int_vbl) begin
            if (vbl_ev_q.size() == 0) chk("int_vbl_unexpected", int'(ly) * 1000 + int'(dot), -1);
            else begin
                ev_t e;
                e = vbl_ev_q.pop_front();
                chk("int_vbl_ly", int'(ly), e.ly);
                chk("int_vbl_dot", int'(dot), e.dot);
            end
        end
        if (cp_q.size() != 0 && cp_q[0].k <= en_cnt) begin
            cp_t c;
            c = cp_q.pop_front();
            if (c.k < en_cnt) chk("checkpoint_missed", en_cnt, c.k);
            else begin
                chk("cp_dot", int'(dot), c.dot);
                chk("cp_ly", int'(ly), c.ly);
                chk("cp_mode", int'(mode), c.mode);
                chk("cp_line_start", int'(line_start), c.ls);
            end
        end
    end

    task automatic wait_k(input int k);
        while (en_cnt < k) @(negedge clk2);
    endtask

    task automatic do_write(input logic [1:0] sel, input logic [7:0] d);
        bus.cpu_wr = 1'b1; bus.reg_sel = sel; bus.wdata = d;
        @(negedge clk2);
        bus.cpu_wr = 1'b0;
    endtask

    task automatic do_read(input logic [1:0] sel, input logic [7:0] exp);
        rd_q.push_back(exp);
        bus.cpu_rd = 1'b1; bus.reg_sel = sel;
        @(negedge clk2);
        bus.cpu_rd = 1'b0;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog expired at en_cnt=%0d", en_cnt);
        $fatal(1);
    end

    initial begin
        reset_video = 1'b1; lcd_en = 1'b1; draw_done = 1'b0;
        bus.cpu_wr = 1'b0; bus.cpu_rd = 1'b0; bus.reg_sel = 2'd0; bus.wdata = 8'h00;
        repeat (3) @(posedge clk2);
        @(negedge clk2);
        chk("reset_dot", int'(dot), 0);
        chk("reset_ly", int'(ly), 0);
        chk("reset_mode", int'(mode), 0);
        chk("reset_rdata", int'(bus.rdata), 0);
        chk("reset_pulses", int'({int_vbl, int_stat, line_start}), 0);
        reset_video = 1'b0; lcd_en = 1'b0;
        repeat (4) @(negedge clk2);
        chk("off_dot_held", int'(dot), 0);
        chk("off_mode_held", int'(mode), 0);

        // Registers writable while off; STAT bits 7 and 2:0 are not writable, coincidence frozen at 0.
        do_write(2'd2, 8'd5);
        do_write(2'd0, 8'hC7);
        do_read(2'd2, 8'd5);
        do_read(2'd0, 8'hC0);

        add_cp(1, 1, 0, 0, 0);
        add_cp(79, 79, 0, 0, 0);
        add_cp(80, 80, 0, 3, 0);
        add_cp(455, 455, 0, 3, 0);
        add_cp(456, 0, 1, 2, 1);
        add_cp(535, 79, 1, 2, 0);
        add_cp(536, 80, 1, 3, 0);
        add_cp(708, 252, 1, 3, 0);
        add_cp(709, 253, 1, 0, 0);
        add_cp(911, 455, 1, 0, 0);
        add_cp(912, 0, 2, 2, 1);
        add_cp(1367, 455, 2, 3, 0);
        add_cp(1368, 0, 3, 2, 1);
        add_cp(2280, 0, 5, 2, 1);
        add_cp(65663, 455, 143, 3, 0);
        add_cp(65664, 0, 144, 1, 1);
        add_cp(69771, 3, 153, 1, 0);
        add_cp(69772, 4, LY153, 1, 0);
        add_cp(70223, 455, LY153, 1, 0);
        add_cp(70224, 0, 0, 2, 1);
        add_cp(70304, 80, 0, 3, 0);

        add_ev_stat(5, 0);
        for (int l = 7; l <= 143; l++) add_ev_stat(l, 0);
        add_ev_stat(0, LAST_STAT_DOT);
        begin
            ev_t e;
            e.ly = 144; e.dot = 0;
            vbl_ev_q.push_back(e);
        end

        lcd_en = 1'b1;

        // draw_done while not in DRAW is ignored (line 0 HBLANK, line 1 OAM)
        wait_k(20);  draw_done = 1'b1;
        wait_k(31);  draw_done = 1'b0;
        wait_k(476); draw_done = 1'b1;
        wait_k(487); draw_done = 1'b0;
        wait_k(708); draw_done = 1'b1;
        wait_k(709); draw_done = 1'b0;

        // Line 5: coincidence with LYC=5
        wait_k(2290); do_read(2'd0, 8'hC6);
        wait_k(2292); do_write(2'd1, 8'h77);
        wait_k(2294); do_write(2'd3, 8'h12);
        wait_k(2296); do_read(2'd1, 8'd5);
        wait_k(2298); do_read(2'd3, 8'hFF);
        wait_k(2300); do_read(2'd2, 8'd5);

        // Line 6 in DRAW: switch to OAM|HBLANK sources
        wait_k(6 * H + 200); do_write(2'd0, 8'h28);

        // Line 146: LYC write matching current LY; old LYC used on the write cycle
        wait_k(146 * H + 100); do_write(2'd2, 8'd146);
        do_read(2'd0, 8'hA9);
        do_read(2'd0, 8'hAD);

        // Line 150: LYC=0 with coincidence source only
        wait_k(150 * H + 10); do_write(2'd2, 8'd0);
        wait_k(150 * H + 12); do_write(2'd0, 8'h40);

        wait_k(70314);

        // Mid-frame reset returns registers to defaults
        reset_video = 1'b1; lcd_en = 1'b0;
        @(negedge clk2);
        reset_video = 1'b0;
        chk("rst2_dot", int'(dot), 0);
        chk("rst2_ly", int'(ly), 0);
        chk("rst2_mode", int'(mode), 0);
        chk("rst2_rdata", int'(bus.rdata), 0);
        do_read(2'd2, 8'h00);
        do_read(2'd0, 8'h80);
        repeat (3) @(negedge clk2);

        chk("leftover_checkpoints", cp_q.size(), 0);
        chk("leftover_stat_pulses", stat_ev_q.size(), 0);
        chk("leftover_vbl_pulses", vbl_ev_q.size(), 0);
        chk("leftover_reads", rd_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
